// File: rtl/reg_file_2w.sv
// Two-read / two-write register file for the decode stage, with optional hardwired zero entry,
// write-to-read bypass and a sequenced reset fill of every entry.
module reg_file_2w #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned ZERO_REG  = 1,
  parameter int unsigned BYPASS    = 1,
  parameter int unsigned INIT_MODE = 1,
  localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] ra0_i,
  input  logic [ADDR_W-1:0] ra1_i,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] wa0_i,
  input  logic [DATA_W-1:0] wd0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] wa1_i,
  input  logic [DATA_W-1:0] wd1_i,
  output logic              init_busy_o
);

  typedef enum logic [0:0] {StInit, StReady} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              busy;
  logic              wen0, wen1;
  logic [DATA_W-1:0] init_val;

  assign busy        = (state_q == StInit);
  assign init_busy_o = busy;

  // Index fill value: zero-extended or truncated to the entry width.
  assign init_val = (INIT_MODE != 0) ? DATA_W'(cnt_q) : '0;

  assign wen0 = we0_i && !busy && !((ZERO_REG != 0) && (wa0_i == '0));
  assign wen1 = we1_i && !busy && !((ZERO_REG != 0) && (wa1_i == '0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (rst_i) begin
      state_d = StInit;
      cnt_d   = '0;
    end else if (state_q == StInit) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == ADDR_W'(DEPTH - 1)) begin
        state_d = StReady;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end

  // Port 1 is written last so it wins an address collision.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (busy) begin
        mem_q[cnt_q] <= init_val;
      end else begin
        if (wen0) mem_q[wa0_i] <= wd0_i;
        if (wen1) mem_q[wa1_i] <= wd1_i;
      end
    end
  end

  function automatic logic [DATA_W-1:0] rd_sel(
    input logic              busy_f,
    input logic [ADDR_W-1:0] ra,
    input logic [DATA_W-1:0] stored,
    input logic              we0,
    input logic [ADDR_W-1:0] wa0,
    input logic [DATA_W-1:0] wd0,
    input logic              we1,
    input logic [ADDR_W-1:0] wa1,
    input logic [DATA_W-1:0] wd1
  );
    logic [DATA_W-1:0] res;
    res = stored;
    if (busy_f) begin
      res = '0;
    end else if ((ZERO_REG != 0) && (ra == '0)) begin
      res = '0;
    end else if ((BYPASS != 0) && we1 && (wa1 == ra)) begin
      res = wd1;
    end else if ((BYPASS != 0) && we0 && (wa0 == ra)) begin
      res = wd0;
    end
    return res;
  endfunction

  always_comb begin
    rdata0_o = rd_sel(busy, ra0_i, mem_q[ra0_i], we0_i, wa0_i, wd0_i, we1_i, wa1_i, wd1_i);
  end

  always_comb begin
    rdata1_o = rd_sel(busy, ra1_i, mem_q[ra1_i], we0_i, wa0_i, wd0_i, we1_i, wa1_i, wd1_i);
  end

endmodule

// File: tb/tb_reg_file_2w.sv
// Bench for reg_file_2w: a default instance (zero reg + bypass) and one without either, both
// driven identically and compared against an array-based reference model.
module tb_reg_file_2w;

  logic        clk;
  logic        rst;
  logic [4:0]  ra0, ra1, wa0, wa1;
  logic        we0, we1;
  logic [31:0] wd0, wd1;
  logic [31:0] rd0a, rd1a, rd0b, rd1b;
  logic        busya, busyb;

  int checks = 0;
  int errors = 0;

  // Reference state: per-instance contents plus shared init progress.
  logic [31:0] ma [32];
  logic [31:0] mb [32];
  bit          mbusy;
  int          icnt;

  reg_file_2w #(.DATA_W(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(1), .INIT_MODE(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .ra0_i(ra0), .ra1_i(ra1), .rdata0_o(rd0a), .rdata1_o(rd1a),
    .we0_i(we0), .wa0_i(wa0), .wd0_i(wd0), .we1_i(we1), .wa1_i(wa1), .wd1_i(wd1),
    .init_busy_o(busya)
  );

  reg_file_2w #(.DATA_W(32), .DEPTH(32), .ZERO_REG(0), .BYPASS(0), .INIT_MODE(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .ra0_i(ra0), .ra1_i(ra1), .rdata0_o(rd0b), .rdata1_o(rd1b),
    .we0_i(we0), .wa0_i(wa0), .wd0_i(wd0), .we1_i(we1), .wa1_i(wa1), .wd1_i(wd1),
    .init_busy_o(busyb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mread(input bit inst_b, input logic [4:0] ra);
    bit zero, byp;
    zero = !inst_b;
    byp  = !inst_b;
    if (mbusy) return 32'h0;
    if (zero && ra == 5'd0) return 32'h0;
    if (byp && we1 && wa1 == ra) return wd1;
    if (byp && we0 && wa0 == ra) return wd0;
    return inst_b ? mb[ra] : ma[ra];
  endfunction

  task automatic check_all();
    chk("busy_a", {31'b0, busya}, {31'b0, mbusy});
    chk("busy_b", {31'b0, busyb}, {31'b0, mbusy});
    chk("rd0_a", rd0a, mread(1'b0, ra0));
    chk("rd1_a", rd1a, mread(1'b0, ra1));
    chk("rd0_b", rd0b, mread(1'b1, ra0));
    chk("rd1_b", rd1b, mread(1'b1, ra1));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      mbusy = 1'b1;
      icnt  = 0;
    end else if (mbusy) begin
      ma[icnt] = 32'(icnt);
      mb[icnt] = 32'(icnt);
      icnt++;
      if (icnt == 32) mbusy = 1'b0;
    end else begin
      if (we0 && wa0 != 5'd0) ma[wa0] = wd0;
      if (we1 && wa1 != 5'd0) ma[wa1] = wd1;
      if (we0) mb[wa0] = wd0;
      if (we1) mb[wa1] = wd1;
    end
    #1;
  endtask

  task automatic cycle();
    #1;
    check_all();
    tick();
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
  endtask

  task automatic randomize_inputs(input bit allow_rst);
    rst = allow_rst && ($urandom_range(0, 63) == 0);
    ra0 = 5'($urandom_range(0, 31));
    ra1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
    we0 = 1'($urandom);
    we1 = 1'($urandom);
    wa0 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
    wa1 = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 31));
    if ($urandom_range(0, 3) == 0) ra0 = wa0;
    if ($urandom_range(0, 3) == 0) ra1 = wa1;
    wd0 = $urandom;
    wd1 = $urandom;
  endtask

  initial begin
    mbusy = 1'b1;
    icnt  = 0;
    for (int i = 0; i < 32; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end
    rst = 1'b1;
    ra0 = 5'd5; ra1 = 5'd31;
    idle();
    tick();
    // Two more reset edges: busy high, reads zero.
    cycle();
    cycle();

    // Release; first init cycle carries a write that must be dropped.
    rst = 1'b0;
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hAA;
    cycle();
    idle();
    for (int i = 1; i < 31; i++) cycle();
    #1;
    chk("busy_before_last", {31'b0, busya}, 32'd1);
    tick();
    #1;
    chk("busy_after_32", {31'b0, busya}, 32'd0);

    ra0 = 5'd5; ra1 = 5'd31;
    cycle();
    chk("init_e5", rd0a, 32'd5);
    chk("init_e31", rd1a, 32'd31);
    ra0 = 5'd0; ra1 = 5'd3;
    #1;
    chk("init_e0", rd0a, 32'd0);
    chk("dropped_init_write", rd1a, 32'd3);
    check_all();
    tick();

    // Basic write with and without bypass.
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hDEADBEEF; ra0 = 5'd7;
    #1;
    chk("bypass_same_cycle", rd0a, 32'hDEADBEEF);
    chk("nobypass_old", rd0b, 32'd7);
    check_all();
    tick();
    idle();
    #1;
    chk("nobypass_next", rd0b, 32'hDEADBEEF);
    chk("stored_a", rd0a, 32'hDEADBEEF);
    tick();

    // Collision: port 1 wins.
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h111;
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h222;
    ra0 = 5'd9; ra1 = 5'd9;
    #1;
    chk("collide_bypass", rd0a, 32'h222);
    check_all();
    tick();
    idle();
    #1;
    chk("collide_stored_a", rd1a, 32'h222);
    chk("collide_stored_b", rd1b, 32'h222);
    tick();

    // Zero register.
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF; ra0 = 5'd0;
    #1;
    chk("zero_same_cycle", rd0a, 32'h0);
    check_all();
    tick();
    idle();
    #1;
    chk("zero_after_a", rd0a, 32'h0);
    chk("zero_off_after_b", rd0b, 32'hFFFF);
    tick();

    for (int i = 0; i < 300; i++) begin
      randomize_inputs(1'b0);
      cycle();
    end

    // Reset mid-operation, then a second reset at init count 10.
    idle();
    we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h55;
    cycle();
    idle();
    ra0 = 5'd4;
    #1;
    chk("pre_reset_e4", rd0a, 32'h55);
    tick();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    chk("busy_reasserted", {31'b0, busya}, 32'd1);
    for (int i = 0; i < 32; i++) cycle();
    #1;
    chk("reinit_e4", rd0a, 32'd4);
    chk("reinit_busy", {31'b0, busya}, 32'd0);
    tick();

    for (int i = 0; i < 400; i++) begin
      randomize_inputs(1'b1);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_2w.md
Name: reg_file_2w

Overview:
- Parametrised successor to the single-port register file: 2 asynchronous read ports, 2 synchronous write ports.
- Optional hardwired-zero register 0 and optional write-to-read bypass.
- Sequenced reset-initialisation engine that fills every entry with zero or its own index, and reports busy while doing so.
- Sits in the decode stage of the pipelined processor. Write port 0 serves ALU writeback and write port 1 serves load writeback.

Parameters:
- DATA_W, 32, data width of each entry.
- DEPTH, 32, number of entries; a power of 2 and at least 2. ADDR_W = clog2(DEPTH) is derived as a localparam.
- ZERO_REG, 1, when 1, entry 0 always reads 0 and writes to it are dropped.
- BYPASS, 1, when 1, a same-cycle write to a read address is forwarded to that read port.
- INIT_MODE, 1: 0 fills every entry with 0; 1 fills entry i with value i, zero-extended to DATA_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset; starts the init sequence.
- ra0  in  ADDR_W  read address, port 0.
- ra1  in  ADDR_W  read address, port 1.
- rdata0  out  DATA_W  read data, port 0; combinational.
- rdata1  out  DATA_W  read data, port 1; combinational.
- we0  in  1  write enable, port 0.
- wa0  in  ADDR_W  write address, port 0.
- wd0  in  DATA_W  write data, port 0.
- we1  in  1  write enable, port 1.
- wa1  in  ADDR_W  write address, port 1.
- wd1  in  DATA_W  write data, port 1.
- init_busy  out  1  high while the init sequence runs; all writes are ignored while high.

Behaviour:
- State machine: INIT and READY, plus an init counter cnt of ADDR_W bits.
- Reset:
  - Any clock edge with rst=1 sets state to INIT and cnt to 0.
  - No array write happens on that edge.
  - init_busy is 1 from the first reset edge on.
  - rst held high keeps the block in INIT with cnt=0.
- INIT, rst=0:
  - Each edge writes entry[cnt] with the init value (0, or cnt when INIT_MODE=1), then cnt increments.
  - The edge that writes entry DEPTH-1 moves the state to READY and clears init_busy.
  - init_busy therefore falls exactly DEPTH edges after the first edge with rst=0.
- Reset mid-init or in READY: the sequence restarts from cnt=0; contents written so far are not guaranteed preserved.
- While init_busy=1:
  - we0 and we1 are ignored.
  - rdata0 and rdata1 read 0. No bypass applies.
- READY, writes:
  - On each edge, if we0 then entry[wa0] <= wd0; if we1 then entry[wa1] <= wd1.
  - If both are enabled with wa0 == wa1, port 1 wins and wd1 is stored.
  - With ZERO_REG=1, any write to address 0 is dropped.
- READY, reads: rdata_k = entry[ra_k], evaluated combinationally.
  - ZERO_REG=1 and ra_k == 0 gives 0, overriding bypass.
  - BYPASS=1 with we1 && wa1 == ra_k gives wd1.
  - Otherwise, BYPASS=1 with we0 && wa0 == ra_k gives wd0.
  - Otherwise the stored entry is returned.
  - With BYPASS=0, the written value is visible from the cycle after the write edge.
- No latches: writes happen only in the clocked process; the array has no combinational write path.
- Init value arithmetic: cnt is zero-extended to DATA_W. If DATA_W < ADDR_W, the value is truncated to DATA_W bits.

Test Plan:
- Init, INIT_MODE=1, DEPTH=32, DATA_W=32:
  - Stimulus: hold rst for 3 cycles, then release.
  - init_busy stays high for exactly 32 edges after release.
  - Reads return 0 during init.
  - After init: ra0=5 gives 5; ra1=31 gives 31; ra0=0 gives 0.
- Basic write and read:
  - Stimulus: we0, wa0=7, wd0=0xDEADBEEF.
  - With BYPASS=1, rdata0 (ra0=7) shows 0xDEADBEEF in the same cycle.
  - With BYPASS=0 it shows the old value 7, then 0xDEADBEEF the next cycle.
- Write collision:
  - Stimulus: we0 and we1 both to wa=9, wd0=0x111, wd1=0x222.
  - Same-cycle bypass and the stored value are both 0x222.
  - Next cycle, ra1=9 reads 0x222.
- Zero register:
  - Stimulus: we0, wa0=0, wd0=0xFFFF.
  - ra0=0 reads 0 in the write cycle and every later cycle.
  - With ZERO_REG=0 it reads 0xFFFF after the edge.
- Write during init:
  - Stimulus: rst released, then we0, wa0=3, wd0=0xAA while init_busy=1.
  - After init completes, ra0=3 reads 3, i.e. the write is dropped.
- Reset mid-operation:
  - Stimulus: in READY, write 0x55 to entry 4, then pulse rst for 1 cycle at init count 10.
  - init_busy is re-asserted; after 32 further edges, entry 4 reads 4.
